// File: rtl/multiword_add_seq_if.sv
// Bundles the request/result handshake and the word-serial adder port of multiword_add_seq.
// The master side is the requester together with the external N-bit adder.
interface multiword_add_seq_if #(
    parameter int N     = 4,
    parameter int WORDS = 4
);
    logic                 start;
    logic [N*WORDS-1:0]   a_in;
    logic [N*WORDS-1:0]   b_in;
    logic                 cin;
    logic                 ready;
    logic                 busy;
    logic [N-1:0]         add_a;
    logic [N-1:0]         add_b;
    logic                 add_cin;
    logic [N-1:0]         add_sum;
    logic                 add_cout;
    logic [N*WORDS-1:0]   result;
    logic                 cout;
    logic                 valid;

    modport master (
        output start, a_in, b_in, cin, add_sum, add_cout,
        input  ready, busy, add_a, add_b, add_cin, result, cout, valid
    );

    modport slave (
        input  start, a_in, b_in, cin, add_sum, add_cout,
        output ready, busy, add_a, add_b, add_cin, result, cout, valid
    );
endinterface

// File: rtl/multiword_add_seq.sv
// Word-serial multi-precision adder controller: feeds one N-bit word per clock, LSW first,
// into an external adder and chains its carry. All outputs come straight from registers.
module multiword_add_seq #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    multiword_add_seq_if.slave bus
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef logic [WORDS-1:0][N-1:0] wordVec_t;

    state_t        state;
    wordVec_t      opA, opB, sumQ;
    logic [IW-1:0] idx;
    logic [N-1:0]  addA, addB;
    logic          addCin, coutQ, readyQ, busyQ, validQ;

    logic [IW-1:0] nxtIdx;
    logic [N-1:0]  nxtA, nxtB;

    // Pre-select the next word so add_a/add_b can be loaded as registers one edge ahead.
    always_comb begin
        nxtIdx = idx + 1'b1;
        nxtA   = '0;
        nxtB   = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (nxtIdx == IW'(k)) begin
                nxtA = opA[k];
                nxtB = opB[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            opA    <= '0;
            opB    <= '0;
            sumQ   <= '0;
            idx    <= '0;
            addA   <= '0;
            addB   <= '0;
            addCin <= 1'b0;
            coutQ  <= 1'b0;
            readyQ <= 1'b1;
            busyQ  <= 1'b0;
            validQ <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    validQ <= 1'b0;
                    if (bus.start) begin
                        opA    <= bus.a_in;
                        opB    <= bus.b_in;
                        sumQ   <= '0;
                        coutQ  <= 1'b0;
                        idx    <= '0;
                        addA   <= bus.a_in[N-1:0];
                        addB   <= bus.b_in[N-1:0];
                        addCin <= bus.cin;
                        readyQ <= 1'b0;
                        busyQ  <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < WORDS; k++) begin
                        if (idx == IW'(k)) sumQ[k] <= bus.add_sum;
                    end
                    idx <= nxtIdx;
                    if (idx == LAST) begin
                        coutQ  <= bus.add_cout;
                        addA   <= '0;
                        addB   <= '0;
                        addCin <= 1'b0;
                        busyQ  <= 1'b0;
                        validQ <= 1'b1;
                        state  <= DONE;
                    end else begin
                        addA   <= nxtA;
                        addB   <= nxtB;
                        addCin <= bus.add_cout;
                    end
                end
                DONE: begin
                    validQ <= 1'b0;
                    readyQ <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    validQ <= 1'b0;
                    busyQ  <= 1'b0;
                    readyQ <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.add_a   = addA;
    assign bus.add_b   = addB;
    assign bus.add_cin = addCin;
    assign bus.result  = sumQ;
    assign bus.cout    = coutQ;
    assign bus.ready   = readyQ;
    assign bus.busy    = busyQ;
    assign bus.valid   = validQ;
endmodule
